restoring_divider_4bit: RTL and testbench

- Sequential 4-bit unsigned restoring divider. Computes quotient and remainder one bit per clock.
- Sits directly upstream of the 4-bit adder/subtractor and drives its A, B and Op inputs.
- Sits directly downstream of the same adder: it consumes the combinational S and Cout in the same cycle to decide each quotient bit.
- The adder is external and combinational. This block holds all state and sequencing.

---
 rtl/restoring_divider_4bit_if.sv | 50 +++++
 rtl/restoring_divider_4bit.sv | 171 +++++++++++++++++
 tb/tb_restoring_divider_4bit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/restoring_divider_4bit_if.sv
// -----------------------------------------------------------------------------
// restoring_divider_4bit_if
// Bundles the request/result handshake of the 4-bit restoring divider together
// with the operand/result bus to the external combinational adder/subtractor.
//
// Signals:
//   start        request a division (sampled at the rising clock edge)
//   dividend     numerator N, captured when start is accepted
//   divisor      denominator D, captured when start is accepted
//   busy         division in progress
//   done         one-cycle result-valid pulse
//   quotient     result Q
//   remainder    result R
//   div_by_zero  last accepted divisor was zero
//   add_a/add_b  adder operands driven by the divider
//   add_op       adder operation, 0 = add, 1 = subtract
//   add_s        adder sum returned to the divider
//   add_cout     adder carry out returned to the divider
//
// Modports:
//   slave   the divider itself
//   master  the requester, which also hosts the adder
// -----------------------------------------------------------------------------
interface restoring_divider_4bit_if;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;
    logic [3:0] add_a;
    logic [3:0] add_b;
    logic       add_op;
    logic [3:0] add_s;
    logic       add_cout;

    modport slave (
        input  start, dividend, divisor, add_s, add_cout,
        output busy, done, quotient, remainder, div_by_zero,
               add_a, add_b, add_op
    );

    modport master (
        output start, dividend, divisor, add_s, add_cout,
        input  busy, done, quotient, remainder, div_by_zero,
               add_a, add_b, add_op
    );
endinterface

// File: rtl/restoring_divider_4bit.sv
// -----------------------------------------------------------------------------
// restoring_divider_4bit
// Sequential 4-bit unsigned restoring divider. One quotient bit is resolved per
// clock using an external combinational 4-bit adder/subtractor: the divider
// presents the shifted partial remainder and the divisor with op=subtract and
// uses the returned carry (1 = no borrow) as the quotient bit.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   bus      restoring_divider_4bit_if.slave (handshake, results, adder bus)
//
// Sequencing (start accepted at edge t):
//   t      IDLE -> LOAD   operands captured
//   t+1    LOAD -> RUN    (D != 0) or LOAD -> DONE with div_by_zero (D == 0)
//   t+2..t+5              four RUN steps, MSB of N first, last one -> DONE
//   done is high for the single cycle spent in DONE; start is ignored outside IDLE.
// -----------------------------------------------------------------------------
module restoring_divider_4bit #(
    parameter int WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    restoring_divider_4bit_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] n_q;          // captured dividend
    logic [WIDTH-1:0] d_q;          // captured divisor
    logic [WIDTH-1:0] p_q;          // partial remainder
    logic [WIDTH-1:0] qsr_q;        // quotient shift register
    logic [1:0]       count_q;      // RUN step index, 0..3
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] shift_s;      // partial remainder shifted with next dividend bit
    logic [WIDTH-1:0] p_d;
    logic [WIDTH-1:0] qsr_d;
    logic [WIDTH-1:0] add_a_s;
    logic [WIDTH-1:0] add_b_s;
    logic             add_op_s;

    // Next partial remainder / quotient and the adder operand drive for this step.
    always_comb begin
        shift_s  = {p_q[2:0], n_q[2'd3 - count_q]};
        add_a_s  = 4'd0;
        add_b_s  = 4'd0;
        add_op_s = 1'b0;
        p_d      = shift_s;
        qsr_d    = {qsr_q[2:0], bus.add_cout};

        if (state_q == S_RUN) begin
            add_a_s  = shift_s;
            add_b_s  = d_q;
            add_op_s = 1'b1;
        end else begin
            add_a_s  = 4'd0;
            add_b_s  = 4'd0;
            add_op_s = 1'b0;
        end

        // Carry out of A - D means no borrow: keep the difference, otherwise
        // restore by keeping the shifted value untouched.
        if (bus.add_cout) begin
            p_d = bus.add_s;
        end else begin
            p_d = shift_s;
        end
    end

    // Control FSM with all datapath and result registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            n_q         <= 4'd0;
            d_q         <= 4'd0;
            p_q         <= 4'd0;
            qsr_q       <= 4'd0;
            count_q     <= 2'd0;
            quotient_q  <= 4'd0;
            remainder_q <= 4'd0;
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        n_q     <= bus.dividend;
                        d_q     <= bus.divisor;
                        p_q     <= 4'd0;
                        qsr_q   <= 4'd0;
                        count_q <= 2'd0;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end

                S_LOAD: begin
                    if (d_q == 4'd0) begin
                        // Division by zero: saturate quotient, pass N through.
                        quotient_q  <= 4'hF;
                        remainder_q <= n_q;
                        dbz_q       <= 1'b1;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        state_q     <= S_RUN;
                    end
                end

                S_RUN: begin
                    p_q     <= p_d;
                    qsr_q   <= qsr_d;
                    count_q <= count_q + 2'd1;
                    if (count_q == 2'd3) begin
                        quotient_q  <= qsr_d;
                        remainder_q <= p_d;
                        dbz_q       <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        state_q     <= S_RUN;
                    end
                end

                S_DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.add_a       = add_a_s;
    assign bus.add_b       = add_b_s;
    assign bus.add_op      = add_op_s;

endmodule

// File: tb/tb_restoring_divider_4bit.sv
// -----------------------------------------------------------------------------
// tb_restoring_divider_4bit
// Directed stimulus issues divisions and pushes the expected result (and the
// cycle at which done must appear) into a scoreboard queue; an independent
// monitor pops and compares on every done pulse. The external adder is
// modelled here as a plain 5-bit add/subtract.
// -----------------------------------------------------------------------------
module tb_restoring_divider_4bit;

    logic clk;
    logic reset_n;
    int   cyc;
    int   checks;
    int   errors;

    typedef struct {
        logic [3:0] q;
        logic [3:0] r;
        logic       z;
        int         cyc;
    } exp_t;

    exp_t sb[$];

    restoring_divider_4bit_if bus ();

    restoring_divider_4bit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // External 4-bit adder/subtractor: subtract is A + ~B + 1, carry = no borrow.
    logic [4:0] sum5;
    always_comb begin
        sum5 = {1'b0, bus.add_a} + {1'b0, (bus.add_op ? ~bus.add_b : bus.add_b)} + {4'd0, bus.add_op};
    end
    assign bus.add_s    = sum5[3:0];
    assign bus.add_cout = sum5[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every done pulse against the oldest expected entry.
    always @(negedge clk) begin
        if (reset_n && bus.done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", int'(bus.quotient), int'(e.q));
                check("remainder", int'(bus.remainder), int'(e.r));
                check("div_by_zero", int'(bus.div_by_zero), int'(e.z));
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Drive one start pulse at the current negedge; optionally record expectation.
    // Returns at the negedge after the accepting edge (LOAD cycle).
    task automatic issue(input logic [3:0] n, input logic [3:0] d,
                         input logic [3:0] q, input logic [3:0] r,
                         input logic z, input bit expect_done);
        exp_t e;
        bus.start    = 1'b1;
        bus.dividend = n;
        bus.divisor  = d;
        e.q   = q;
        e.r   = r;
        e.z   = z;
        e.cyc = cyc + 1 + ((d == 4'd0) ? 1 : 5);
        if (expect_done) sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_div(input logic [3:0] n, input logic [3:0] d,
                           input logic [3:0] q, input logic [3:0] r, input logic z);
        issue(n, d, q, r, z, 1'b1);
        repeat (7) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        cyc          = 0;
        checks       = 0;
        errors       = 0;
        reset_n      = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = 4'd0;
        bus.divisor  = 4'd0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_quotient", int'(bus.quotient), 0);
        check("rst_remainder", int'(bus.remainder), 0);
        check("rst_dbz", int'(bus.div_by_zero), 0);
        check("idle_add_op", int'(bus.add_op), 0);
        check("idle_add_a", int'(bus.add_a), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Basic 13/3 with adder bus observed during the four RUN cycles
        issue(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 1'b1);
        check("load_busy", int'(bus.busy), 1);
        check("load_add_op", int'(bus.add_op), 0);
        @(negedge clk);
        check("run0_add_a", int'(bus.add_a), 1);
        for (int k = 0; k < 4; k++) begin
            check("run_busy", int'(bus.busy), 1);
            check("run_add_op", int'(bus.add_op), 1);
            check("run_add_b", int'(bus.add_b), 3);
            @(negedge clk);
        end
        check("done_busy", int'(bus.busy), 0);
        check("done_add_b", int'(bus.add_b), 0);
        repeat (3) @(negedge clk);

        // Extremes
        run_div(4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
        run_div(4'd7, 4'd9, 4'd0, 4'd7, 1'b0);
        run_div(4'd15, 4'd15, 4'd1, 4'd0, 1'b0);
        run_div(4'd0, 4'd5, 4'd0, 4'd0, 1'b0);

        // Divide by zero followed by a normal division
        run_div(4'd6, 4'd0, 4'd15, 4'd6, 1'b1);
        check("dbz_hold", int'(bus.div_by_zero), 1);
        run_div(4'd8, 4'd2, 4'd4, 4'd0, 1'b0);

        // Start while busy is ignored
        issue(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 1'b1);
        bus.start    = 1'b1;
        bus.dividend = 4'd15;
        bus.divisor  = 4'd1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        check("hold_quotient", int'(bus.quotient), 4);

        // Reset in the middle of RUN aborts without a done pulse
        issue(4'd12, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_quotient", int'(bus.quotient), 0);
        check("abort_remainder", int'(bus.remainder), 0);
        repeat (8) @(negedge clk);
        run_div(4'd12, 4'd5, 4'd2, 4'd2, 1'b0);

        // Exhaustive sweep against reference arithmetic
        for (int n = 0; n < 16; n++) begin
            for (int d = 0; d < 16; d++) begin
                if (d == 0)
                    run_div(4'(n), 4'd0, 4'hF, 4'(n), 1'b1);
                else
                    run_div(4'(n), 4'(d), 4'(n / d), 4'(n % d), 1'b0);
            end
        end

        check("pending_results", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
